// File: rtl/mem_stage_unit.sv
// Memory pipeline stage: multi-cycle load/store against a local word-addressed
// data memory, stalling upstream via freeze and registering results for write-back.
module mem_stage_unit #(
  parameter int DEPTH     = 64,
  parameter int LATENCY   = 4,
  parameter int BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_en_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] ST_val_in,
  input  logic [4:0]  Dest_in,
  output logic        freeze,
  output logic        WB_en,
  output logic        MEM_R_EN,
  output logic [31:0] ALU_result,
  output logic [31:0] MEM_read_value,
  output logic [4:0]  Dest,
  output logic        addr_err
);

  localparam int CW = $clog2(LATENCY) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST    = CW'(LATENCY - 1);
  localparam logic [31:0]   BASE    = 32'(BASE_ADDR);
  localparam logic [31:0]   DEPTH_W = 32'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OUT_PASS, OUT_BUBBLE, OUT_COMPLETE} out_sel_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  out_sel_t       out_sel;

  logic           access, is_store, is_load, in_range;
  logic [31:0]    offset, word;
  logic [AW-1:0]  idx;
  logic [31:0]    mem [DEPTH];

  // A simultaneous read+write request is treated as a store.
  assign access   = MEM_R_EN_in | MEM_W_EN_in;
  assign is_store = MEM_W_EN_in;
  assign is_load  = MEM_R_EN_in & ~MEM_W_EN_in;
  assign offset   = ALU_result_in - BASE;
  assign word     = offset >> 2;
  assign idx      = word[AW-1:0];
  assign in_range = (ALU_result_in >= BASE) && (word < DEPTH_W);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    freeze    = 1'b0;
    out_sel   = OUT_PASS;
    unique case (state)
      IDLE: begin
        if (access) begin
          if (LATENCY == 1) begin
            out_sel = OUT_COMPLETE;
          end else begin
            freeze    = 1'b1;
            out_sel   = OUT_BUBBLE;
            state_nxt = BUSY;
            cnt_nxt   = CW'(1);
          end
        end
      end
      BUSY: begin
        if (cnt == LAST) begin
          out_sel   = OUT_COMPLETE;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          freeze    = 1'b1;
          out_sel   = OUT_BUBBLE;
          cnt_nxt   = cnt + CW'(1);
        end
      end
    endcase
    if (rst) freeze = 1'b0;
  end

  // NOTE: the data memory is deliberately not reset; contents survive rst and
  // a reset during an access suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!rst && out_sel == OUT_COMPLETE && is_store && in_range)
      mem[idx] <= ST_val_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WB_en          <= 1'b0;
      MEM_R_EN       <= 1'b0;
      ALU_result     <= '0;
      MEM_read_value <= '0;
      Dest           <= '0;
      addr_err       <= 1'b0;
    end else begin
      unique case (out_sel)
        OUT_PASS: begin
          WB_en          <= WB_en_in;
          MEM_R_EN       <= 1'b0;
          ALU_result     <= ALU_result_in;
          MEM_read_value <= '0;
          Dest           <= Dest_in;
          addr_err       <= 1'b0;
        end
        OUT_COMPLETE: begin
          WB_en          <= WB_en_in;
          MEM_R_EN       <= is_load;
          ALU_result     <= ALU_result_in;
          MEM_read_value <= (is_load && in_range) ? mem[idx] : '0;
          Dest           <= Dest_in;
          addr_err       <= ~in_range;
        end
        default: begin
          WB_en          <= 1'b0;
          MEM_R_EN       <= 1'b0;
          ALU_result     <= '0;
          MEM_read_value <= '0;
          Dest           <= '0;
          addr_err       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: a LATENCY=4 unit (u=0) and a LATENCY=1 unit (u=1).
module tb_mem_stage_unit;

  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  dest;
    logic        addr_err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_in [2];
  logic        rd_in [2];
  logic        wr_in [2];
  logic [31:0] alu_in [2];
  logic [31:0] st_in [2];
  logic [4:0]  dest_in [2];
  logic        freeze_o [2];
  logic        wb_o [2];
  logic        rd_o [2];
  logic [31:0] alu_o [2];
  logic [31:0] rdata_o [2];
  logic [4:0]  dest_o [2];
  logic        err_o [2];

  logic [31:0] ref_mem [2][64];
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;
  int          f1_cnt = 0;

  always #5 clk = ~clk;

  mem_stage_unit #(.DEPTH(64), .LATENCY(4), .BASE_ADDR(1024)) u_lat4 (
    .clk(clk), .rst(rst),
    .WB_en_in(wb_in[0]), .MEM_R_EN_in(rd_in[0]), .MEM_W_EN_in(wr_in[0]),
    .ALU_result_in(alu_in[0]), .ST_val_in(st_in[0]), .Dest_in(dest_in[0]),
    .freeze(freeze_o[0]), .WB_en(wb_o[0]), .MEM_R_EN(rd_o[0]),
    .ALU_result(alu_o[0]), .MEM_read_value(rdata_o[0]), .Dest(dest_o[0]),
    .addr_err(err_o[0])
  );

  mem_stage_unit #(.DEPTH(64), .LATENCY(1), .BASE_ADDR(1024)) u_lat1 (
    .clk(clk), .rst(rst),
    .WB_en_in(wb_in[1]), .MEM_R_EN_in(rd_in[1]), .MEM_W_EN_in(wr_in[1]),
    .ALU_result_in(alu_in[1]), .ST_val_in(st_in[1]), .Dest_in(dest_in[1]),
    .freeze(freeze_o[1]), .WB_en(wb_o[1]), .MEM_R_EN(rd_o[1]),
    .ALU_result(alu_o[1]), .MEM_read_value(rdata_o[1]), .Dest(dest_o[1]),
    .addr_err(err_o[1])
  );

  always @(posedge clk) if (freeze_o[1] === 1'b1) f1_cnt++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] out_vec(input int u);
    return {wb_o[u], rd_o[u], alu_o[u], rdata_o[u], dest_o[u], err_o[u]};
  endfunction

  task automatic set_in(input int u, input logic wb, rd, wr,
                        input logic [31:0] addr, st, input logic [4:0] dst);
    wb_in[u] = wb; rd_in[u] = rd; wr_in[u] = wr;
    alu_in[u] = addr; st_in[u] = st; dest_in[u] = dst;
  endtask

  task automatic compare(input int u, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, " WB_en"},          wb_o[u],    e.wb_en);
    check({tag, " MEM_R_EN"},       rd_o[u],    e.mem_r_en);
    check({tag, " ALU_result"},     alu_o[u],   e.alu);
    check({tag, " MEM_read_value"}, rdata_o[u], e.rdata);
    check({tag, " Dest"},           dest_o[u],  e.dest);
    check({tag, " addr_err"},       err_o[u],   e.addr_err);
  endtask

  // Called at posedge+1: drives an instruction, predicts its MEM/WB result,
  // checks bubbles during the stall and the result after the completion edge.
  task automatic issue(input int u, input logic wb, rd, wr,
                       input logic [31:0] addr, st, input logic [4:0] dst,
                       input int exp_frz, input string tag);
    exp_t e;
    logic ir;
    int   idx;
    int   frz;
    set_in(u, wb, rd, wr, addr, st, dst);
    ir  = (addr >= 32'd1024) && (((addr - 32'd1024) >> 2) < 32'd64);
    idx = int'((addr - 32'd1024) >> 2);
    e.wb_en    = wb;
    e.mem_r_en = rd & ~wr;
    e.alu      = addr;
    e.rdata    = '0;
    e.dest     = dst;
    e.addr_err = (rd | wr) & ~ir;
    if (wr) begin
      if (ir) ref_mem[u][idx] = st;
    end else if (rd && ir) begin
      e.rdata = ref_mem[u][idx];
    end
    sb.push_back(e);
    frz = 0;
    #1;
    while (freeze_o[u] === 1'b1 && frz < 20) begin
      frz++;
      @(posedge clk); #1;
      check({tag, " stall_bubble"}, out_vec(u), '0);
    end
    check({tag, " freeze_cycles"}, frz, exp_frz);
    @(posedge clk); #1;
    compare(u, tag);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 1'b1, 1'b1, 1'b0, 32'd1028, 32'hCAFE, 5'd3);
    set_in(1, 1'b1, 1'b0, 1'b1, 32'd1036, 32'hBEEF, 5'd4);
    #1;
    check("reset freeze_u0", freeze_o[0], 1'b0);
    check("reset freeze_u1", freeze_o[1], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs_u0", out_vec(0), '0);
    check("reset outputs_u1", out_vec(1), '0);
    check("reset freeze_held", freeze_o[0], 1'b0);

    set_in(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    set_in(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst = 1'b0;
    #1;
    check("post_reset freeze", freeze_o[0], 1'b0);
    @(posedge clk); #1;
    check("post_reset idle_freeze", freeze_o[0], 1'b0);

    issue(0, 1'b1, 1'b0, 1'b0, 32'h1234,   32'h0,        5'd7, 0, "passthru");
    issue(0, 1'b0, 1'b0, 1'b1, 32'd1028,   32'hDEADBEEF, 5'd0, 3, "store_1028");
    issue(0, 1'b1, 1'b1, 1'b0, 32'd1028,   32'h0,        5'd5, 3, "load_1028");
    issue(0, 1'b1, 1'b1, 1'b0, 32'd1020,   32'h0,        5'd9, 3, "load_oor_low");
    issue(0, 1'b0, 1'b0, 1'b0, 32'h42,     32'h0,        5'd2, 0, "err_cleared");
    issue(0, 1'b0, 1'b0, 1'b1, 32'd1276,   32'hA5A50063, 5'd0, 3, "store_idx63");
    issue(0, 1'b0, 1'b0, 1'b1, 32'd1280,   32'hFFFFFFFF, 5'd0, 3, "store_oor_high");
    issue(0, 1'b1, 1'b1, 1'b0, 32'd1276,   32'h0,        5'd4, 3, "load_idx63");
    issue(0, 1'b1, 1'b1, 1'b1, 32'd1040,   32'h77,       5'd6, 3, "rd_wr_store");
    issue(0, 1'b1, 1'b1, 1'b0, 32'd1040,   32'h0,        5'd6, 3, "load_1040");
    issue(0, 1'b0, 1'b0, 1'b1, 32'd1032,   32'h11111111, 5'd0, 3, "store_1032_prior");

    // Abandon a store to 1032 once cnt reaches 2.
    set_in(0, 1'b0, 1'b0, 1'b1, 32'd1032, 32'h55, 5'd0);
    #1;
    check("midrst freeze_start", freeze_o[0], 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("midrst freeze_cnt2", freeze_o[0], 1'b1);
    rst = 1'b1;
    #1;
    check("midrst freeze_drop", freeze_o[0], 1'b0);
    @(posedge clk); #1;
    check("midrst outputs", out_vec(0), '0);
    rst = 1'b0;
    set_in(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("midrst idle_freeze", freeze_o[0], 1'b0);
    @(posedge clk); #1;
    issue(0, 1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 5'd8, 3, "load_1032_after_rst");
    set_in(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    issue(1, 1'b0, 1'b0, 1'b1, 32'd1036, 32'h55AA, 5'd0, 0, "lat1_store_1036");
    issue(1, 1'b1, 1'b1, 1'b0, 32'd1036, 32'h0,    5'd3, 0, "lat1_load_1036");
    set_in(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    check("lat1 freeze_never", f1_cnt, 0);
    check("scoreboard drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
